// File: rtl/load_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_access_ctrl                                             |
// | Description : Sequences MEM-stage loads onto word-addressed Data Memory.   |
// |               Loads crossing a word boundary take two word reads whose     |
// |               data are merged, shifted and sign/zero extended.             |
// | Config macro: MISALIGN_TRAP_EN - split loads trap instead of being read.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module load_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err
);

  // Register-write mode encodings shared with the core's decoder.
  localparam logic [2:0] NOREGWRITE = 3'd0;
  localparam logic [2:0] LB         = 3'd1;
  localparam logic [2:0] LH         = 3'd2;
  localparam logic [2:0] LW         = 3'd3;
  localparam logic [2:0] LBU        = 3'd4;
  localparam logic [2:0] LHU        = 3'd5;

  localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ0 = 3'd1,
    DAT0 = 3'd2,
    REQ1 = 3'd3,
    DAT1 = 3'd4,
    EXT  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        type_q;
  logic [31:0]       lo_q;
  logic [31:0]       hi_q;
  logic [31:0]       lo_nxt;
  logic [31:0]       hi_nxt;
  logic              accept;
  logic              split_q;

  // A load needs a second word when its last byte lies in the next word.
  function automatic logic is_split(input logic [1:0] ofs, input logic [2:0] t);
    return ((t == LH || t == LHU) && ofs == 2'd3) || (t == LW && ofs != 2'd0);
  endfunction

  // Little-endian merge of the two words, then width selection and extension.
  function automatic logic [31:0] extend(input logic [2:0] t, input logic [63:0] pair,
                                         input logic [1:0] ofs);
    logic [63:0] w;
    w = pair >> {ofs, 3'b000};
    case (t)
      LB:      return {{24{w[7]}}, w[7:0]};
      LBU:     return {24'b0, w[7:0]};
      LH:      return {{16{w[15]}}, w[15:0]};
      LHU:     return {16'b0, w[15:0]};
      LW:      return w[31:0];
      default: return 32'b0;
    endcase
  endfunction

  assign accept  = req_valid && (req_type != NOREGWRITE) && !flush;
  assign split_q = is_split(addr_q[1:0], type_q);

  // Next values of the read-data holding registers; a flush discards the read.
  assign lo_nxt = (state == DAT0 && !flush) ? mem_rdata : lo_q;
  assign hi_nxt = (state == DAT1 && !flush) ? mem_rdata :
                  (state == DAT0 && !flush) ? 32'b0     : hi_q;

  // Hold the pipeline for any real load until its response cycle; reset forces release.
  assign stall = rst_n && req_valid && (req_type != NOREGWRITE) && !resp_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and memory/response strobes.
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_addr   = '0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef MISALIGN_TRAP_EN
          state_nxt = is_split(req_addr[1:0], req_type) ? EXT : REQ0;
`else
          state_nxt = REQ0;
`endif
        end
      end
      REQ0: begin
        mem_req  = 1'b1;
        mem_addr = addr_q[ADDR_W-1:2];
        if (mem_gnt) state_nxt = DAT0;
      end
      DAT0: state_nxt = split_q ? REQ1 : EXT;
      REQ1: begin
        mem_req  = 1'b1;
        mem_addr = addr_q[ADDR_W-1:2] + WORD_ONE;
        if (mem_gnt) state_nxt = DAT1;
      end
      DAT1: state_nxt = EXT;
      EXT: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // An abort wins over everything; a read granted this cycle still goes out.
    if (flush) begin
      state_nxt  = IDLE;
      resp_valid = 1'b0;
    end
  end

  // Request capture, read-data holding and the registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      type_q    <= NOREGWRITE;
      lo_q      <= 32'b0;
      hi_q      <= 32'b0;
      resp_data <= 32'b0;
    end else begin
      if (state == IDLE && accept) begin
        addr_q <= req_addr;
        type_q <= req_type;
      end
      lo_q <= lo_nxt;
      hi_q <= hi_nxt;
      // Entering EXT straight from IDLE only happens for a trapped load.
      if (state_nxt == EXT) begin
        resp_data <= (state == IDLE) ? 32'b0 : extend(type_q, {hi_nxt, lo_nxt}, addr_q[1:0]);
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic err_q;

  // Remember whether the accepted load is a trapped split access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      err_q <= 1'b0;
    else if (state == IDLE && accept) err_q <= is_split(req_addr[1:0], req_type);
  end

  assign resp_err = resp_valid && err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_load_access_ctrl                                          |
// | Description : Self-checking bench for load_access_ctrl (table vectors,     |
// |               random loads against a byte-level reference model).         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_load_access_ctrl;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_LB   = 3'd1;
  localparam logic [2:0] T_LH   = 3'd2;
  localparam logic [2:0] T_LW   = 3'd3;
  localparam logic [2:0] T_LBU  = 3'd4;
  localparam logic [2:0] T_LHU  = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic        flush;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_data = 32'b0;

  load_access_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_type(req_type), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .stall(stall), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Memory contents: a few fixed words, a deterministic pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [29:0] w);
    case (w)
      30'h40:       return 32'h44332211;
      30'h41:       return 32'h88776655;
      30'h3FFFFFFF: return 32'hDDCCBBAA;
      30'h0:        return 32'h12345678;
      default:      return {w[15:0], ~w[15:0]} ^ 32'h5A5AC3C3;
    endcase
  endfunction

  // Data is valid only the cycle after a granted request; garbage otherwise.
  always @(posedge clk) begin
    if (mem_req && mem_gnt) mem_rdata <= mem_word(mem_addr);
    else                    mem_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: fetch the load's bytes one by one, then extend.
  function automatic void ref_load(input logic [31:0] a, input logic [2:0] t,
                                   output logic [31:0] d, output logic e, output int reads);
    int          n;
    logic [31:0] v;
    logic [31:0] ba;
    logic [31:0] wd;
    bit          spl;
    n = (t == T_LB || t == T_LBU) ? 1 : (t == T_LH || t == T_LHU) ? 2 : 4;
    v = 32'b0;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      wd = mem_word(ba[31:2]);
      v  = v | (((wd >> (8 * int'(ba[1:0]))) & 32'hFF) << (8 * i));
    end
    case (t)
      T_LB:    d = 32'($signed(v[7:0]));
      T_LH:    d = 32'($signed(v[15:0]));
      default: d = v;
    endcase
    spl = (int'(a[1:0]) + n) > 4;
`ifdef MISALIGN_TRAP_EN
    e     = spl;
    reads = spl ? 0 : 1;
    if (spl) d = 32'b0;
`else
    e     = 1'b0;
    reads = spl ? 2 : 1;
`endif
  endfunction

  // gmode: 0 = grant always, 1 = random grant, 2 = grant withheld for 3 cycles.
  task automatic do_load(input logic [31:0] a, input logic [2:0] t, input logic [31:0] ed,
                         input logic ee, input int er, input int gmode);
    int          nreads;
    int          waits;
    bit          done;
    logic [29:0] w0;
    nreads = 0;
    waits  = 0;
    done   = 0;
    w0     = a[31:2];
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_type = t; mem_gnt = 1'b1;
    #1;
    if (t == T_NONE) begin
      chk("noreg_stall", {31'b0, stall}, 32'd0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); #1;
        chk("noreg_mem_req", {31'b0, mem_req}, 32'd0);
        chk("noreg_resp_valid", {31'b0, resp_valid}, 32'd0);
      end
      req_valid = 1'b0;
      return;
    end
    chk("accept_stall", {31'b0, stall}, 32'd1);
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      case (gmode)
        0:       mem_gnt = 1'b1;
        1:       mem_gnt = ($urandom_range(0, 3) != 0);
        default: mem_gnt = (cyc > 3);
      endcase
      #1;
      if (mem_req) begin
        chk("read_count", {31'b0, nreads < er}, 32'd1);
        chk("mem_addr", {2'b0, mem_addr}, {2'b0, w0 + 30'(nreads)});
        if (mem_gnt) nreads++;
        else         waits++;
      end
      if (resp_valid) begin
        done = 1;
        chk("resp_data", resp_data, ed);
        chk("resp_err", {31'b0, resp_err}, {31'b0, ee});
        chk("latency", cyc, 1 + 2 * er + waits);
        chk("reads", nreads, er);
        chk("ext_stall", {31'b0, stall}, 32'd0);
        last_data = ed;
      end else begin
        chk("busy_stall", {31'b0, stall}, 32'd1);
      end
    end
    if (!done) chk("resp_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  // Flush at cycle k after presenting the request (k=0 is the IDLE cycle).
  task automatic flush_at(input logic [31:0] a, input logic [2:0] t, input int k);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_type = t; mem_gnt = 1'b1; flush = (k == 0);
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      flush = (c == k);
    end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("flush_mem_req", {31'b0, mem_req}, 32'd0);
      chk("flush_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("flush_resp_hold", resp_data, last_data);
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  typ;
    logic [31:0] data;
    logic        err;
    int          reads;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t tv(input logic [31:0] a, input logic [2:0] t,
                              input logic [31:0] d, input bit spl);
    vec_t v;
    v.addr = a;
    v.typ  = t;
`ifdef MISALIGN_TRAP_EN
    v.data  = spl ? 32'b0 : d;
    v.err   = spl;
    v.reads = spl ? 0 : 1;
`else
    v.data  = d;
    v.err   = 1'b0;
    v.reads = spl ? 2 : 1;
`endif
    return v;
  endfunction

  initial begin
    logic [31:0] a;
    logic [2:0]  t;
    logic [31:0] d;
    logic        e;
    int          r;

    rst_n = 1'b0; req_valid = 1'b1; req_addr = 32'h100; req_type = T_LW;
    flush = 1'b0; mem_gnt = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", {2'b0, mem_addr}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back(tv(32'h100,      T_LW,   32'h44332211, 0));
    vecs.push_back(tv(32'h107,      T_LB,   32'hFFFFFF88, 0));
    vecs.push_back(tv(32'h107,      T_LBU,  32'h00000088, 0));
    vecs.push_back(tv(32'h103,      T_LB,   32'h00000044, 0));
    vecs.push_back(tv(32'h106,      T_LHU,  32'h00008877, 0));
    vecs.push_back(tv(32'h103,      T_LH,   32'h00005544, 1));
    vecs.push_back(tv(32'h102,      T_LW,   32'h66554433, 1));
    vecs.push_back(tv(32'hFFFFFFFE, T_LW,   32'h5678DDCC, 1));
    vecs.push_back(tv(32'h106,      T_LH,   32'hFFFF8877, 0));
    vecs.push_back(tv(32'h101,      T_LH,   32'h00003322, 0));
    vecs.push_back(tv(32'h100,      T_NONE, 32'h0,        0));
    vecs.push_back(tv(32'h104,      T_LB,   32'h00000055, 0));
    foreach (vecs[i]) do_load(vecs[i].addr, vecs[i].typ, vecs[i].data, vecs[i].err, vecs[i].reads, 0);

    // Grant withheld three cycles in REQ0.
    do_load(32'h100, T_LW, 32'h44332211, 1'b0, 1, 2);

    // Random loads against the reference model.
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 1) == 0) ? (32'h100 + 32'($urandom_range(0, 15))) : 32'($urandom);
      t = 3'($urandom_range(0, 5));
      ref_load(a, t, d, e, r);
      do_load(a, t, d, e, r, 1);
    end

    // Flush in IDLE, REQ0 and DAT0; REQ1 only exists when split loads are serviced.
    flush_at(32'h100, T_LW, 0);
    flush_at(32'h100, T_LW, 1);
    flush_at(32'h104, T_LW, 2);
`ifndef MISALIGN_TRAP_EN
    flush_at(32'h103, T_LH, 3);
    flush_at(32'h103, T_LH, 4);
`endif
    do_load(32'h106, T_LHU, 32'h00008877, 1'b0, 1, 0);

    // Asynchronous reset while a request is on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h100; req_type = T_LW; mem_gnt = 1'b0;
    @(negedge clk); #1;
    chk("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("async_rst_stall", {31'b0, stall}, 32'd0);
    chk("async_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("async_rst_resp_data", resp_data, 32'd0);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    last_data = 32'b0;
    @(negedge clk); #1;
    chk("post_rst_mem_req", {31'b0, mem_req}, 32'd0);
    do_load(32'h107, T_LB, 32'hFFFFFF88, 1'b0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
